// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: core data-bus slice seen by the UART transmitter (address/write data in, registered read data out)
interface uart_tx_mmio_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        rsel;
  modport master (output address, wdata, we, input rdata, rsel);
  modport slave (input address, wdata, we, output rdata, rsel);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO; TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic resetn,
  uart_tx_mmio_if.slave bus,
  output logic tx,
  output logic irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic overflow, empty, full, busy, tick, pop, push, push_req, hit_data, hit_stat, tx_n, last_bit;
  logic unused;
  assign unused   = ^{bus.address[1:0], bus.wdata[31:8]};
  assign hit_data = bus.address[31:2] == BASE_ADDR[31:2];
  assign hit_stat = bus.address[31:2] == STAT_ADDR[31:2];
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign busy     = state != IDLE;
  assign tick     = cnt == CW'(CLK_DIV - 1);
  assign push_req = bus.we & hit_data;
  assign push     = push_req & (~full | pop);
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk) par <= pop ? ^mem[rd_ptr] : par;
  assign last_bit = par;
`else
  assign last_bit = 1'b1;
`endif
  always_ff @(posedge clk)
    state <= !resetn ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = empty ? IDLE : START;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && bit_idx == 3'd7 ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  state_n = tick ? STOP : PARITY;
`endif
      STOP:    state_n = tick ? (empty ? IDLE : START) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // A pop always starts a frame, so the start bit goes out on the same edge.
  always_comb begin
    pop  = !empty && (state == IDLE || (state == STOP && tick));
    tx_n = pop ? 1'b0 : !tick ? tx :
           state == START ? shift[0] :
           state == DATA && bit_idx != 3'd7 ? shift[1] :
           state == DATA ? last_bit : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
    shift   <= pop ? mem[rd_ptr] : (state == DATA && tick) ? shift >> 1 : shift;
    bit_idx <= state == START ? 3'd0 : (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
    cnt     <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx        <= 1'b1;
      irq       <= 1'b1;
      bus.rdata <= '0;
      bus.rsel  <= 1'b0;
    end else begin
      rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      count     <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow  <= (push_req & full & ~pop) ? 1'b1 : (bus.we & hit_stat & bus.wdata[3]) ? 1'b0 : overflow;
      tx        <= tx_n;
      irq       <= empty & ~busy;
      bus.rdata <= hit_stat ? {28'b0, overflow, busy, empty, full} : 32'b0;
      bus.rsel  <= hit_data | hit_stat;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed plus random bus traffic, every cycle compared against a queue-and-frame model of the UART
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int CLK_DIV = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  logic clk = 1'b0, resetn = 1'b0, tx, irq;
  uart_tx_mmio_if bus ();
  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit act, ovf;
  logic [7:0] cur;
  int pos;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FL == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic rn);
    logic [31:0] e_rd;
    logic e_rsel, e_irq;
    bit hd, hs;
    @(negedge clk);
    bus.address = a; bus.wdata = d; bus.we = w; resetn = rn;
    @(posedge clk);
    hd = a[31:2] == BASE[31:2];
    hs = a[31:2] == STAT[31:2];
    if (!rn) begin
      e_rd = 0; e_rsel = 0; e_irq = 1;
      q.delete(); act = 0; pos = 0; ovf = 0;
    end else begin
      e_rsel = hd | hs;
      e_rd = hs ? {28'b0, ovf, act, q.size() == 0, q.size() == DEPTH} : 32'b0;
      e_irq = q.size() == 0 && !act;
      if (act) begin
        pos++;
        if (pos == FL * CLK_DIV) begin
          if (q.size() != 0) begin cur = q.pop_front(); pos = 0; end
          else act = 0;
        end
      end else if (q.size() != 0) begin
        cur = q.pop_front(); act = 1; pos = 0;
      end
      if (w && hd) begin
        if (q.size() < DEPTH) q.push_back(d[7:0]);
        else ovf = 1;
      end
      if (w && hs && d[3]) ovf = 0;
    end
    #1;
    chk("tx", tx, act ? fbit(cur, pos / CLK_DIV) : 1'b1);
    chk("rdata", bus.rdata, e_rd);
    chk("rsel", bus.rsel, e_rsel);
    chk("irq", irq, e_irq);
  endtask
  task automatic idle(input int n);
    repeat (n) step(32'h0, 32'h0, 1'b0, 1'b1);
  endtask
  initial begin
    int r;
    bus.address = 0; bus.wdata = 0; bus.we = 0;
    repeat (2) step(0, 0, 0, 0);
    idle(50);
    step(STAT, 0, 0, 1);
    idle(2);
    step(BASE, 32'h55, 1, 1);
    idle(45);
    step(BASE, 32'h41, 1, 1);
    step(BASE | 32'h3, 32'hFFFF_FF42, 1, 1);
    idle(90);
    for (int i = 0; i < 10; i++) step(BASE, 32'h30 + i, 1, 1);
    step(STAT | 32'h2, 0, 0, 1);
    step(STAT, 32'h8, 1, 1);
    step(STAT, 0, 0, 1);
    idle(420);
    step(BASE, 32'hA5, 1, 1);
    idle(15);
    step(0, 0, 0, 0);
    step(STAT, 0, 0, 1);
    idle(60);
    step(BASE, 32'h07, 1, 1);
    idle(50);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 300) step(BASE | ($urandom & 32'h3), $urandom, 1, 1);
      else if (r < 400) step(STAT | ($urandom & 32'h3), $urandom, 0, 1);
      else if (r < 430) step(STAT, $urandom, 1, 1);
      else if (r < 460) step(32'h2000_0000 | ($urandom & 32'hFF), $urandom, 1, 1);
      else if (r < 480) step(BASE, $urandom, 0, 1);
      else if (r < 483) step(0, 0, 0, 0);
      else idle(1);
    end
    idle(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the core's data bus, downstream of the core's address/data_out/we port.
- Decodes two word registers at BASE_ADDR.
- Buffers written bytes in a small FIFO and serialises them as 8N1 frames on tx.
- Returns status through a registered read port that the top-level muxes into the core's data_in.

Parameters:
BASE_ADDR, 32'h1000_0000, word-aligned base; TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4
CLK_DIV, 16, clk cycles per serial bit (>=2)
FIFO_DEPTH, 8, byte entries (power of two, >=2)

Ports:
clk  input  1  clock
resetn  input  1  synchronous reset, active low
address  input  32  byte address from core
wdata  input  32  write data from core (core's data_out)
we  input  1  write strobe from core
rdata  output  32  read data, registered
rsel  output  1  registered; high when rdata belongs to this block (top-level data_in mux select)
tx  output  1  serial line, idle high, registered
irq  output  1  high while FIFO empty and transmitter idle

Behaviour:
- Single clock. Reset is synchronous, active-low (resetn sampled on posedge clk).
- Reset values: tx=1, rdata=0, rsel=0, irq=1, FIFO empty, overflow=0, FSM=IDLE.
- Reset mid-frame aborts the frame. tx=1 from the reset edge on; FIFO contents are discarded.
- Decode: hit_data when address[31:2]==BASE_ADDR[31:2]; hit_stat when address[31:2]==(BASE_ADDR+4)[31:2]. address[1:0] is ignored.
- TXDATA write (we & hit_data): pushes wdata[7:0]. Push is accepted if FIFO is not full, or if a pop occurs the same edge.
- Push while full with no simultaneous pop: byte is dropped and overflow (sticky) is set.
- STATUS write (we & hit_stat): overflow cleared when wdata[3]=1. Other bits are ignored.
- Writes to any other address are ignored.
- Read path:
  - At every edge, rsel <= hit_data|hit_stat, independent of we.
  - On hit_stat: rdata <= {28'b0, overflow, busy, empty, full}.
  - On hit_data: rdata <= 0.
  - Otherwise: rdata <= 0.
  - Read latency is one cycle, aligned with the core's mdr capture.
- FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..CLK_DIV-1; bit_idx runs 0..7.
- IDLE:
  - FIFO non-empty: pop the head into shift register, tx<=0, go to START.
  - Net effect: tx falls one edge after the accepting write edge.
- START: after CLK_DIV cycles → DATA, tx<=shift[0].
- DATA:
  - Each CLK_DIV cycles, shift right and bit_idx++, LSB first.
  - After bit 7's CLK_DIV cycles → STOP, tx<=1.
- STOP, after CLK_DIV cycles:
  - FIFO non-empty: pop, tx<=0, go to START. No idle gap between frames.
  - FIFO empty: → IDLE.
- Frame length is exactly 10*CLK_DIV cycles without parity.
- busy=1 whenever FSM!=IDLE. irq = empty & ~busy, registered.
- Pointer wrap uses log2(FIFO_DEPTH)-bit pointers plus a count of log2(FIFO_DEPTH)+1 bits. Full = count==FIFO_DEPTH.

Optional Feature:
UART_TX_PARITY_EN
- Defined: FSM gains a PARITY state between DATA and STOP. tx carries even parity (XOR of the 8 data bits). Frame is 11*CLK_DIV cycles.
- Undefined: no PARITY state; 8N1, 10*CLK_DIV cycles.

Test Plan:
1. Reset, then idle 50 cycles → tx=1, irq=1, read STATUS returns 32'h2 (empty) one cycle after address presented, rsel=1.
2. CLK_DIV=4: write 0x55 to BASE → tx low one edge later. Observed bits for 4 cycles each: 0,1,0,1,0,1,0,1,0,1. tx=1 after 40 cycles. busy cleared; irq=1.
3. Write 0x41 then 0x42 back-to-back → second START begins exactly 40 cycles after the first; no idle cycle between frames.
4. FIFO_DEPTH=8: write 10 bytes in 10 consecutive cycles while the first frame starts.
   - 9 bytes accepted: one popped, 8 buffered.
   - 10th dropped; STATUS = full|busy|overflow = 32'hD.
   - Write 0x8 to STATUS → overflow cleared.
5. Assert resetn=0 for one cycle mid-DATA → tx=1 at that edge, STATUS reads 32'h2, no further frames transmitted.
6. With UART_TX_PARITY_EN, write 0x07 → parity bit 1 after data bits, frame 44 cycles at CLK_DIV=4. Without the macro the frame is 40 cycles.
